// File: rtl/blowfish_pkg.sv
// Shared constants, types and FSM state encoding for the Blowfish Feistel
// engine.
//   NUM_ROUNDS / P_ENTRIES / P_ADDR_W : network geometry
//   word_t, paddr_t, round_t          : datapath, P index and round counter
//   P_WHITEN_R / P_WHITEN_L           : encrypt-order output whitening entries
//   state_t                           : engine FSM states
//   p_mirror()                        : maps an encrypt P index to decrypt order
package blowfish_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int P_ENTRIES  = 18;
    localparam int P_ADDR_W   = 5;
    localparam int ROUND_W    = 4;

    typedef logic [31:0]         word_t;
    typedef logic [P_ADDR_W-1:0] paddr_t;
    typedef logic [ROUND_W-1:0]  round_t;

    localparam paddr_t P_WHITEN_R = 5'd16;
    localparam paddr_t P_WHITEN_L = 5'd17;
    localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        PL,
        XL,
        FX,
        XR,
        FP,
        FR,
        FL,
        DONE
    } state_t;

    // Decrypt walks the P-array back to front: entry i becomes 17 - i.
    function automatic paddr_t p_mirror(input paddr_t idx);
        return paddr_t'(P_ENTRIES - 1) - idx;
    endfunction

endpackage

// File: rtl/blowfish_feistel_core_if.sv
// Signal bundle between the Feistel engine and its environment: the block
// input stream, the result stream, the P-array read port and the F stage.
//   slave  : the engine side (consumes blocks, drives P address and F input)
//   master : the environment side (supplies blocks, P data and F output)
//
// Both streams transfer on a rising clk edge where valid and ready are both
// high; the valid side keeps valid and payload stable until that edge.
interface blowfish_feistel_core_if;
    import blowfish_pkg::*;

    logic   in_valid;
    logic   in_ready;
    logic   in_decrypt;
    word_t  in_l;
    word_t  in_r;
    logic   out_valid;
    logic   out_ready;
    word_t  out_l;
    word_t  out_r;
    paddr_t p_addr;
    word_t  p_data;
    word_t  f_x;
    word_t  f_y;

    modport slave (
        input  in_valid, in_decrypt, in_l, in_r, out_ready, p_data, f_y,
        output in_ready, out_valid, out_l, out_r, p_addr, f_x
    );

    modport master (
        output in_valid, in_decrypt, in_l, in_r, out_ready, p_data, f_y,
        input  in_ready, out_valid, out_l, out_r, p_addr, f_x
    );

endinterface

// File: rtl/bf_p_index.sv
// Combinational P-array index generator.
//   state   : current engine state
//   r       : current round (0..15)
//   decrypt : latched direction, 1 = decrypt
//   p_addr  : P index to read; 0 in states that do not read the P-array
module bf_p_index
    import blowfish_pkg::*;
(
    input  state_t state,
    input  round_t r,
    input  logic   decrypt,
    output paddr_t p_addr
);

    paddr_t enc_idx;
    logic   reads_p;

    always_comb begin
        enc_idx = '0;
        reads_p = 1'b0;
        case (state)
            PL: begin
                enc_idx = paddr_t'(r);
                reads_p = 1'b1;
            end
            FP: begin
                enc_idx = P_WHITEN_R;
                reads_p = 1'b1;
            end
            FR: begin
                enc_idx = P_WHITEN_L;
                reads_p = 1'b1;
            end
            default: ;
        endcase

        if (!reads_p) begin
            p_addr = '0;
        end else if (decrypt) begin
            p_addr = p_mirror(enc_idx);
        end else begin
            p_addr = enc_idx;
        end
    end

endmodule

// File: rtl/blowfish_feistel_core.sv
// Iterative Blowfish Feistel engine. One block at a time runs 16 rounds of
// four cycles each (PL, XL, FX, XR) followed by output whitening (FP, FR, FL)
// and is then held in DONE until the consumer takes it.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : block input/output streams, P-array port, F stage port
//   dbg_state : current FSM state, for observation only
// The P-array read and the F stage each return data one cycle after the
// address / input is presented, which is why every read gets its own cycle.
module blowfish_feistel_core
    import blowfish_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    blowfish_feistel_core_if.slave  bus,
    output state_t                  dbg_state
);

    state_t state, state_nx;
    word_t  xl, xl_nx;
    word_t  xr, xr_nx;
    round_t r, r_nx;
    logic   decrypt, decrypt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            xl      <= '0;
            xr      <= '0;
            r       <= '0;
            decrypt <= 1'b0;
        end else begin
            state   <= state_nx;
            xl      <= xl_nx;
            xr      <= xr_nx;
            r       <= r_nx;
            decrypt <= decrypt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        xl_nx      = xl;
        xr_nx      = xr;
        r_nx       = r;
        decrypt_nx = decrypt;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    xl_nx      = bus.in_l;
                    xr_nx      = bus.in_r;
                    decrypt_nx = bus.in_decrypt;
                    r_nx       = '0;
                    state_nx   = PL;
                end
            end
            PL: state_nx = XL;
            XL: begin
                xl_nx    = xl ^ bus.p_data;
                state_nx = FX;
            end
            FX: state_nx = XR;
            XR: begin
                r_nx = r + 4'd1;
                if (r == LAST_ROUND) begin
                    // The final round skips the swap so whitening sees the
                    // halves in output order.
                    xr_nx    = xr ^ bus.f_y;
                    state_nx = FP;
                end else begin
                    xl_nx    = xr ^ bus.f_y;
                    xr_nx    = xl;
                    state_nx = PL;
                end
            end
            FP: state_nx = FR;
            FR: begin
                xr_nx    = xr ^ bus.p_data;
                state_nx = FL;
            end
            FL: begin
                xl_nx    = xl ^ bus.p_data;
                state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    bf_p_index u_p_index (
        .state   (state),
        .r       (r),
        .decrypt (decrypt),
        .p_addr  (bus.p_addr)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_l     = xl;
    assign bus.out_r     = xr;
    assign bus.f_x       = xl;
    assign dbg_state     = state;

endmodule
